// File: rtl/spu_cache_rd_stream.sv
// Burst reader: issues single-cycle reads of consecutive cache rows and streams the
// returned rows downstream through a 2-entry FIFO on a valid/ready interface.
module spu_cache_rd_stream #(
  parameter int DATA_WIDTH = 1024,
  parameter int DATA_DEPTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_DEPTH-1:0] base_addr,
  input  logic [DATA_DEPTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  cache_we,
  output logic [DATA_DEPTH-1:0] cache_addr,
  input  logic [DATA_WIDTH-1:0] cache_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DATA_DEPTH:0]   CNT_ONE  = 1;
  localparam logic [DATA_DEPTH-1:0] ADDR_ONE = 1;

  logic [1:0]            state_reg, state_next;
  logic [DATA_DEPTH-1:0] rd_addr_reg;
  logic [DATA_DEPTH-1:0] addr_hold_reg;
  logic [DATA_DEPTH:0]   issue_cnt_reg;
  logic                  inflight_reg;
  logic                  inflight_last_reg;
  logic [1:0]            fifo_count_reg;
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;

  logic       pop;
  logic       push;
  logic       issue;
  logic       issue_last;
  logic       head_last;
  logic [2:0] credit_used;

  assign pop  = m_valid & m_ready;
  assign push = inflight_reg;

  // Rows held plus rows in flight may never exceed the two FIFO slots; a pop this
  // cycle frees a slot immediately so streaming continues without bubbles.
  assign credit_used = {1'b0, fifo_count_reg} + {2'b00, inflight_reg};
  assign issue       = (state_reg == S_RUN) && (credit_used < (3'd2 + {2'b00, pop}));
  assign issue_last  = issue && (issue_cnt_reg == CNT_ONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = (len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (issue_last) state_next = S_DRAIN;
      S_DRAIN: if (pop && m_last) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      rd_addr_reg       <= '0;
      addr_hold_reg     <= '0;
      issue_cnt_reg     <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      fifo_count_reg    <= 2'd0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && start && len != '0) begin
        rd_addr_reg   <= base_addr;
        issue_cnt_reg <= len;
      end else if (issue) begin
        rd_addr_reg   <= rd_addr_reg + ADDR_ONE;
        issue_cnt_reg <= issue_cnt_reg - CNT_ONE;
      end
      if (issue) addr_hold_reg <= rd_addr_reg;
      inflight_reg      <= issue;
      inflight_last_reg <= issue_last;
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      fifo_count_reg <= fifo_count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // Each FIFO slot captures the cache row the cycle after its read was issued.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  last_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_reg <= '0;
        last_reg <= 1'b0;
      end else if (push && (wr_ptr_reg == 1'(gi))) begin
        data_reg <= cache_dout;
        last_reg <= inflight_last_reg;
      end
    end
  end

  assign m_data    = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
  assign head_last = rd_ptr_reg ? g_entry[1].last_reg : g_entry[0].last_reg;
  assign m_valid   = (fifo_count_reg != 2'd0);
  assign m_last    = m_valid & head_last;

  assign busy       = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign done       = (state_reg == S_DONE);
  assign cache_we   = 1'b0;
  assign cache_addr = issue ? rd_addr_reg : addr_hold_reg;

endmodule

// File: tb/tb_spu_cache_rd_stream.sv
// Directed bench for spu_cache_rd_stream: a registered-read cache model feeds the DUT,
// accepted beats are recorded per cycle and compared against hand-derived sequences.
module tb_spu_cache_rd_stream;

  localparam int DW = 1024;
  localparam int DD = 9;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DD-1:0] base_addr;
  logic [DD:0]   len;
  logic          busy;
  logic          done;
  logic          cache_we;
  logic [DD-1:0] cache_addr;
  logic [DW-1:0] cache_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  spu_cache_rd_stream #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .cache_we(cache_we), .cache_addr(cache_addr),
    .cache_dout(cache_dout), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cache row holds a distinct word pattern derived from its address.
  function automatic logic [DW-1:0] pat(input int a);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++)
      r[i*32 +: 32] = (32'(a) * 32'h0100_0193) ^ (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    return r;
  endfunction

  initial cache_dout = '0;
  always @(posedge clk) cache_dout <= pat(int'(cache_addr));

  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc_n    = 0;
  logic          bp_mode  = 1'b0;
  logic [DW-1:0] beat_data[$];
  logic          beat_last[$];
  int            beat_cyc[$];
  int            done_cyc[$];
  int            busy_cnt, busy_first, busy_last, addr_changes;
  logic          we_seen = 1'b0;
  logic          stall_prev;
  logic [DW-1:0] prev_data;
  logic [DD-1:0] prev_addr;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic observe();
    if (m_valid && m_ready) begin
      beat_data.push_back(m_data);
      beat_last.push_back(m_last);
      beat_cyc.push_back(cyc_n);
    end
    if (done) done_cyc.push_back(cyc_n);
    if (busy) begin
      if (busy_cnt == 0) busy_first = cyc_n;
      busy_last = cyc_n;
      busy_cnt++;
    end
    if (cache_we) we_seen = 1'b1;
    if (cache_addr != prev_addr) addr_changes++;
    prev_addr = cache_addr;
    if (!rst && stall_prev) begin
      check("stall_valid", DW'(m_valid), DW'(1));
      check("stall_data", m_data, prev_data);
    end
    stall_prev = !rst && m_valid && !m_ready;
    prev_data  = m_data;
  endtask

  task automatic settle_obs();
    if (bp_mode) m_ready = 1'($urandom_range(0, 1));
    #2;
    observe();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic run_cycle();
    settle_obs();
    adv();
  endtask

  task automatic clear();
    beat_data.delete();
    beat_last.delete();
    beat_cyc.delete();
    done_cyc.delete();
    busy_cnt     = 0;
    busy_first   = -1;
    busy_last    = -1;
    addr_changes = 0;
    stall_prev   = 1'b0;
    prev_addr    = cache_addr;
  endtask

  task automatic start_cmd(input int b, input int n);
    clear();
    start     = 1'b1;
    base_addr = DD'(b);
    len       = (DD+1)'(n);
    cyc_n     = 0;
    run_cycle();
    start     = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int b, input int n);
    int bad_data = 0;
    int bad_last = 0;
    check({tag, "_count"}, DW'(beat_data.size()), DW'(n));
    for (int k = 0; k < beat_data.size() && k < n; k++) begin
      if (beat_data[k] !== pat((b + k) % 512)) bad_data++;
      if (beat_last[k] !== (k == n - 1)) bad_last++;
    end
    check({tag, "_data_errs"}, DW'(bad_data), DW'(0));
    check({tag, "_last_errs"}, DW'(bad_last), DW'(0));
  endtask

  function automatic int first_done();
    return (done_cyc.size() > 0) ? done_cyc[0] : -1;
  endfunction

  initial begin
    int bad_cyc;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_valid", DW'(m_valid), DW'(0));
    check("rst_last", DW'(m_last), DW'(0));
    check("rst_addr", DW'(cache_addr), DW'(0));
    check("rst_data", m_data, DW'(0));
    check("rst_we", DW'(cache_we), DW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single row: base 5, len 1
    m_ready = 1'b1;
    start_cmd(5, 1);
    repeat (7) run_cycle();
    check_stream("single", 5, 1);
    check("single_beat_cyc", DW'((beat_cyc.size() > 0) ? beat_cyc[0] : -1), DW'(3));
    check("single_done_cnt", DW'(done_cyc.size()), DW'(1));
    check("single_done_cyc", DW'(first_done()), DW'(4));
    check("single_busy_first", DW'(busy_first), DW'(1));
    check("single_busy_last", DW'(busy_last), DW'(3));
    check("single_busy_cnt", DW'(busy_cnt), DW'(3));
    $display("single row: %0d beats, done at cycle %0d", beat_data.size(), first_done());

    // Full burst with address wrap: base 500, len 512
    start_cmd(500, 512);
    repeat (520) run_cycle();
    check_stream("burst", 500, 512);
    bad_cyc = 0;
    for (int k = 0; k < beat_cyc.size(); k++) if (beat_cyc[k] != 3 + k) bad_cyc++;
    check("burst_gaps", DW'(bad_cyc), DW'(0));
    check("burst_done_cnt", DW'(done_cyc.size()), DW'(1));
    check("burst_done_cyc", DW'(first_done()), DW'(515));
    check("burst_we", DW'(we_seen), DW'(0));
    $display("burst: %0d beats, done at cycle %0d", beat_data.size(), first_done());

    // Backpressure: random 50% ready, base 100, len 8
    bp_mode = 1'b1;
    start_cmd(100, 8);
    for (int c = 0; c < 200 && done_cyc.size() == 0; c++) run_cycle();
    bp_mode = 1'b0;
    m_ready = 1'b1;
    repeat (3) run_cycle();
    check("bp_done_cnt", DW'(done_cyc.size()), DW'(1));
    check_stream("bp", 100, 8);
    $display("backpressure: %0d beats, done at cycle %0d", beat_data.size(), first_done());

    // Zero-length command
    start_cmd(7, 0);
    repeat (5) run_cycle();
    check("len0_done_cnt", DW'(done_cyc.size()), DW'(1));
    check("len0_done_cyc", DW'(first_done()), DW'(1));
    check("len0_beats", DW'(beat_data.size()), DW'(0));
    check("len0_addr_moves", DW'(addr_changes), DW'(0));
    check("len0_busy", DW'(busy_cnt), DW'(0));
    $display("len0: done at cycle %0d, addr changes %0d", first_done(), addr_changes);

    // Second start while busy is ignored
    start_cmd(20, 6);
    while (cyc_n < 16) begin
      if (cyc_n == 3) begin
        start = 1'b1; base_addr = DD'(300); len = (DD+1)'(2);
      end else begin
        start = 1'b0;
      end
      run_cycle();
    end
    start = 1'b0;
    check_stream("busy_start", 20, 6);
    check("busy_start_done_cnt", DW'(done_cyc.size()), DW'(1));
    check("busy_start_done_cyc", DW'(first_done()), DW'(9));
    $display("start during busy: %0d beats, %0d done pulses", beat_data.size(), done_cyc.size());

    // Reset after 3 of 10 rows accepted
    start_cmd(40, 10);
    while (cyc_n < 6) run_cycle();
    rst = 1'b1;
    m_ready = 1'b0;
    run_cycle();
    rst = 1'b0;
    #2;
    check("abort_busy", DW'(busy), DW'(0));
    check("abort_done", DW'(done), DW'(0));
    check("abort_valid", DW'(m_valid), DW'(0));
    check("abort_last", DW'(m_last), DW'(0));
    check("abort_addr", DW'(cache_addr), DW'(0));
    check("abort_data", m_data, DW'(0));
    @(posedge clk);
    #1;
    cyc_n++;
    repeat (6) run_cycle();
    check("abort_beats", DW'(beat_data.size()), DW'(3));
    check("abort_no_done", DW'(done_cyc.size()), DW'(0));
    $display("reset mid-burst: %0d beats before abort, %0d done pulses", beat_data.size(), done_cyc.size());

    m_ready = 1'b1;
    start_cmd(0, 2);
    repeat (7) run_cycle();
    check_stream("after_rst", 0, 2);
    check("after_rst_done_cyc", DW'(first_done()), DW'(5));
    check("final_we", DW'(we_seen), DW'(0));
    $display("post-reset command: %0d beats, done at cycle %0d", beat_data.size(), first_done());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
